// File: rtl/lease_sampler_multi.sv
// lease_sampler_multi: reuse-interval sampler with an N_TABLE-entry tag table and a dual-port
// record buffer of {pc, interval, trace, tag} entries read concurrently by the host.
module lease_sampler_multi #(
    parameter int unsigned N_TABLE  = 16,
    parameter int unsigned BW_TAG   = 20,
    parameter int unsigned BW_CNT   = 32,
    parameter int unsigned N_BUFFER = 4096,
    parameter int unsigned BW_BUF   = 12,
    parameter int unsigned BW_RATE  = 9
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               enable_i,
    input  logic               mode_i,
    input  logic [BW_RATE-1:0] period_i,
    input  logic               clear_i,
    input  logic               flush_i,
    input  logic               req_i,
    input  logic [31:0]        pc_i,
    input  logic [BW_TAG-1:0]  tag_i,
    input  logic [7:0]         phase_i,
    input  logic [BW_BUF-1:0]  rd_addr_i,
    output logic [127:0]       rd_data_o,
    output logic [BW_BUF:0]    used_o,
    output logic [31:0]        count_o,
    output logic               busy_o,
    output logic               full_o,
    output logic               stall_o
);

    function automatic logic [31:0] lfsr_taps(input int unsigned w);
        case (w)
            2:       return 32'h3;
            3:       return 32'h6;
            4:       return 32'hC;
            5:       return 32'h14;
            6:       return 32'h30;
            7:       return 32'h60;
            8:       return 32'hB8;
            9:       return 32'h110;
            10:      return 32'h240;
            11:      return 32'h500;
            12:      return 32'hE08;
            13:      return 32'h1C80;
            14:      return 32'h3802;
            15:      return 32'h6000;
            16:      return 32'hD008;
            default: return (32'h1 << (w - 1)) | 32'h1;
        endcase
    endfunction

    localparam int unsigned IDX_W  = $clog2(N_TABLE);
    localparam int unsigned SCAN_W = IDX_W + 1;
    localparam int unsigned PTR_W  = BW_BUF + 1;
    localparam logic [BW_CNT-1:0]  CNT_MAX   = {1'b0, {(BW_CNT-1){1'b1}}};
    localparam logic [BW_RATE-1:0] LFSR_TAPS = BW_RATE'(lfsr_taps(BW_RATE));

    typedef enum logic [1:0] {NORMAL, EVICT, FLUSH} state_t;

    function automatic logic [BW_CNT-1:0] sat_inc(input logic [BW_CNT-1:0] c);
        return (c >= CNT_MAX) ? c : c + BW_CNT'(1);
    endfunction

    state_t             state_q, state_d;
    logic [N_TABLE-1:0] valid_q, valid_d;
    logic [BW_TAG-1:0]  tag_q [N_TABLE];
    logic [BW_TAG-1:0]  tag_d [N_TABLE];
    logic [BW_CNT-1:0]  cnt_q [N_TABLE];
    logic [BW_CNT-1:0]  cnt_d [N_TABLE];
    logic [31:0]        pcr_q [N_TABLE];
    logic [31:0]        pcr_d [N_TABLE];
    logic [31:0]        trace_q, trace_d;
    logic [BW_RATE-1:0] rate_q, rate_d, lfsr_q, lfsr_d, thresh, lfsr_step;
    logic [SCAN_W-1:0]  scan_q, scan_d;
    logic [IDX_W-1:0]   best_q, best_d, scan_idx, ins_idx;
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [31:0]        count_q;

    logic               hit_any, free_any, accept, full, mem_we;
    logic [IDX_W-1:0]   hit_idx, free_idx;
    logic               rec_we, rec_neg;
    logic [IDX_W-1:0]   rec_idx;
    logic [BW_CNT-1:0]  rec_cnt;
    logic [31:0]        ival;
    logic [127:0]       rec_data;
    logic [BW_BUF-1:0]  mem_addr;
    logic [23:0]        pc_lo;
    logic               pc_hi_unused;
    logic [127:0]       mem [N_BUFFER];

    assign full      = (wr_ptr_q == PTR_W'(N_BUFFER));
    assign accept    = (state_q == NORMAL) && enable_i && req_i && !full;
    assign thresh    = mode_i ? period_i : lfsr_q;
    assign lfsr_step = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_TAPS) : (lfsr_q >> 1);
    assign scan_idx  = scan_q[IDX_W-1:0];
    assign pc_lo     = pc_i[23:0] - 24'd4;
    assign pc_hi_unused = ^pc_i[31:24];

    // Lowest-index hit and lowest-index free slot, both from the pre-update valid vector.
    always_comb begin
        hit_any  = 1'b0;
        hit_idx  = '0;
        free_any = 1'b0;
        free_idx = '0;
        for (int unsigned i = 0; i < N_TABLE; i++) begin
            if (!hit_any && valid_q[i] && (tag_q[i] == tag_i)) begin
                hit_any = 1'b1;
                hit_idx = IDX_W'(i);
            end
            if (!free_any && !valid_q[i]) begin
                free_any = 1'b1;
                free_idx = IDX_W'(i);
            end
        end
    end

    always_comb begin
        state_d = state_q;
        valid_d = valid_q;
        tag_d   = tag_q;
        cnt_d   = cnt_q;
        pcr_d   = pcr_q;
        trace_d = trace_q;
        rate_d  = rate_q;
        lfsr_d  = lfsr_q;
        scan_d  = scan_q;
        best_d  = best_q;
        ins_idx = free_any ? free_idx : hit_idx;
        rec_we  = 1'b0;
        rec_neg = 1'b0;
        rec_idx = '0;
        rec_cnt = '0;
        unique case (state_q)
            NORMAL: begin
                if (accept) begin
                    trace_d = trace_q + 32'd1;
                    for (int unsigned i = 0; i < N_TABLE; i++)
                        if (valid_q[i]) cnt_d[i] = sat_inc(cnt_q[i]);
                    if (hit_any) begin
                        rec_we           = 1'b1;
                        rec_idx          = hit_idx;
                        rec_cnt          = sat_inc(cnt_q[hit_idx]);
                        valid_d[hit_idx] = 1'b0;
                    end
                    if (rate_q == thresh) begin
                        rate_d = '0;
                        lfsr_d = lfsr_step;
                        // A hit entry is only recycled when no free slot existed before the hit.
                        if (free_any || hit_any) begin
                            valid_d[ins_idx] = 1'b1;
                            tag_d[ins_idx]   = tag_i;
                            cnt_d[ins_idx]   = '0;
                            pcr_d[ins_idx]   = {phase_i, pc_lo};
                        end
                    end else begin
                        rate_d = rate_q + BW_RATE'(1);
                    end
                    if (&valid_d) begin
                        state_d = EVICT;
                        scan_d  = '0;
                    end
                end
                if (flush_i) begin
                    state_d = FLUSH;
                    scan_d  = '0;
                end
            end
            EVICT: begin
                if (flush_i) begin
                    state_d = FLUSH;
                    scan_d  = '0;
                end else if (scan_q == SCAN_W'(N_TABLE)) begin
                    rec_we          = 1'b1;
                    rec_neg         = 1'b1;
                    rec_idx         = best_q;
                    rec_cnt         = cnt_q[best_q];
                    valid_d[best_q] = 1'b0;
                    state_d         = NORMAL;
                end else begin
                    if ((scan_q == '0) || (cnt_q[scan_idx] > cnt_q[best_q]))
                        best_d = scan_idx;
                    scan_d = scan_q + SCAN_W'(1);
                end
            end
            FLUSH: begin
                if (valid_q[scan_idx]) begin
                    rec_we            = 1'b1;
                    rec_neg           = 1'b1;
                    rec_idx           = scan_idx;
                    rec_cnt           = cnt_q[scan_idx];
                    valid_d[scan_idx] = 1'b0;
                end
                if (scan_q == SCAN_W'(N_TABLE - 1))
                    state_d = NORMAL;
                else
                    scan_d = scan_q + SCAN_W'(1);
            end
            default: state_d = NORMAL;
        endcase
    end

    always_comb begin
        ival     = rec_neg ? (32'd0 - 32'(rec_cnt)) : 32'(rec_cnt);
        rec_data = {pcr_q[rec_idx], ival, trace_q, 32'(tag_q[rec_idx])};
        mem_we   = rec_we && (clear_i || !full) && !reset_i;
        mem_addr = clear_i ? '0 : wr_ptr_q[BW_BUF-1:0];
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i) begin
            state_q  <= NORMAL;
            valid_q  <= '0;
            tag_q    <= '{default: '0};
            cnt_q    <= '{default: '0};
            pcr_q    <= '{default: '0};
            trace_q  <= '0;
            rate_q   <= '0;
            lfsr_q   <= BW_RATE'(1);
            scan_q   <= '0;
            best_q   <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= valid_d;
            tag_q   <= tag_d;
            cnt_q   <= cnt_d;
            pcr_q   <= pcr_d;
            trace_q <= trace_d;
            rate_q  <= rate_d;
            lfsr_q  <= lfsr_d;
            scan_q  <= scan_d;
            best_q  <= best_d;
            count_q <= count_q + 32'(rec_we);
            if (clear_i)
                wr_ptr_q <= rec_we ? PTR_W'(1) : '0;
            else if (rec_we && !full)
                wr_ptr_q <= wr_ptr_q + PTR_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (mem_we) mem[mem_addr] <= rec_data;
    end

    always_ff @(posedge clock_i or posedge reset_i) begin
        if (reset_i)
            rd_data_o <= '0;
        else if ({1'b0, rd_addr_i} < wr_ptr_q)
            rd_data_o <= mem[rd_addr_i];
        else
            rd_data_o <= '0;
    end

    assign used_o  = wr_ptr_q;
    assign count_o = count_q;
    assign busy_o  = (state_q != NORMAL);
    assign full_o  = full;
    assign stall_o = full | busy_o;

endmodule

// File: tb/tb_lease_sampler_multi.sv
// Directed bench for lease_sampler_multi: table-driven reference vectors plus hand sequences
// for eviction, flush, saturation, buffer full/clear, LFSR seed and asynchronous reset.
module tb_lease_sampler_multi;
    localparam int unsigned NT = 4, BT = 20, BC = 5, NB = 8, BB = 3, BR = 9;
    localparam logic [19:0] TA = 20'hAAAAA, TB = 20'h0BBBB, TC = 20'h00CCC, TQ = 20'h0FFFF;

    logic          clk = 1'b0, rst = 1'b1, en = 1'b1, mode = 1'b1, clear = 1'b0, flush = 1'b0, req = 1'b0;
    logic [BR-1:0] period = '0;
    logic [31:0]   pc = '0;
    logic [BT-1:0] tag = '0;
    logic [7:0]    phase = '0;
    logic [BB-1:0] rd_addr = '0;
    logic [127:0]  rd_data;
    logic [BB:0]   used;
    logic [31:0]   count;
    logic          busy, full, stall;

    int n_cmp = 0;
    int n_fail = 0;

    lease_sampler_multi #(.N_TABLE(NT), .BW_TAG(BT), .BW_CNT(BC), .N_BUFFER(NB), .BW_BUF(BB), .BW_RATE(BR)) dut (
        .clock_i(clk), .reset_i(rst), .enable_i(en), .mode_i(mode), .period_i(period),
        .clear_i(clear), .flush_i(flush), .req_i(req), .pc_i(pc), .tag_i(tag), .phase_i(phase),
        .rd_addr_i(rd_addr), .rd_data_o(rd_data), .used_o(used), .count_o(count),
        .busy_o(busy), .full_o(full), .stall_o(stall)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        en;
        logic        req;
        logic [19:0] tag;
        logic [31:0] pc;
        logic [7:0]  ph;
        int          used;
        int          cnt;
        logic        stall;
    } vec_t;

    vec_t vt [8];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_ref(input logic [19:0] t, input logic [31:0] p, input logic [7:0] ph);
        req = 1'b1; tag = t; pc = p; phase = ph;
        step();
        req = 1'b0;
    endtask

    function automatic logic [127:0] rec(input logic [7:0] ph, input logic [31:0] p,
                                         input logic [31:0] iv, input logic [31:0] tr, input logic [19:0] t);
        logic [23:0] pl;
        pl = p[23:0] - 24'd4;
        return {ph, pl, iv, tr, 12'h000, t};
    endfunction

    task automatic read_chk(input string nm, input int a, input logic [127:0] exp);
        rd_addr = BB'(a);
        step();
        chk(nm, rd_data, exp);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = 1'b0; flush = 1'b0; clear = 1'b0; en = 1'b1; mode = 1'b1; period = '0; rd_addr = '0;
        step(); step();
        rst = 1'b0;
        step();
    endtask

    task automatic wait_busy(input string nm, input int exp_cycles);
        int n;
        n = 0;
        while (busy && n < 64) begin
            n++;
            step();
        end
        chk(nm, n, exp_cycles);
    endtask

    initial begin
        vt[0] = '{1'b1, 1'b1, TA, 32'h104, 8'h01, 0, 0, 1'b0};
        vt[1] = '{1'b1, 1'b1, TB, 32'h208, 8'h01, 0, 0, 1'b0};
        vt[2] = '{1'b1, 1'b1, TA, 32'h30C, 8'h02, 1, 1, 1'b0};
        vt[3] = '{1'b1, 1'b1, TC, 32'h400, 8'h03, 1, 1, 1'b0};
        vt[4] = '{1'b1, 1'b1, TB, 32'h500, 8'h04, 2, 2, 1'b0};
        vt[5] = '{1'b1, 1'b0, TB, 32'h500, 8'h04, 2, 2, 1'b0};
        vt[6] = '{1'b0, 1'b1, TA, 32'h600, 8'h05, 2, 2, 1'b0};
        vt[7] = '{1'b1, 1'b1, TA, 32'h700, 8'h06, 3, 3, 1'b0};

        // Reset state
        do_reset();
        chk("reset used", used, 0);
        chk("reset count", count, 0);
        chk("reset busy", busy, 0);
        chk("reset full", full, 0);
        chk("reset stall", stall, 0);
        chk("reset rd_data", rd_data, 0);

        // Table-driven: fixed period 0, hits, idle and disabled cycles
        for (int i = 0; i < 8; i++) begin
            en = vt[i].en; req = vt[i].req; tag = vt[i].tag; pc = vt[i].pc; phase = vt[i].ph;
            step();
            req = 1'b0; en = 1'b1;
            chk($sformatf("row%0d used", i), used, vt[i].used);
            chk($sformatf("row%0d count", i), count, vt[i].cnt);
            chk($sformatf("row%0d stall", i), stall, vt[i].stall);
        end
        read_chk("vec rec0", 0, rec(8'h01, 32'h104, 32'd2, 32'd2, TA));
        read_chk("vec rec1", 1, rec(8'h01, 32'h208, 32'd3, 32'd4, TB));
        read_chk("vec rec2", 2, rec(8'h02, 32'h30C, 32'd3, 32'd5, TA));
        read_chk("vec rd past used", 3, 128'd0);
        read_chk("vec rd top", 7, 128'd0);

        // LFSR mode: seed 1 means the second reference is the first sample
        do_reset();
        mode = 1'b0;
        do_ref(TC, 32'h800, 8'h07);
        do_ref(TB, 32'h900, 8'h08);
        chk("lfsr no early rec", used, 0);
        do_ref(TB, 32'hA00, 8'h09);
        chk("lfsr used", used, 1);
        read_chk("lfsr rec0", 0, rec(8'h08, 32'h900, 32'd1, 32'd2, TB));

        // Eviction: four distinct tags fill the table
        do_reset();
        for (int i = 0; i < 4; i++) do_ref(20'h00100 + 20'(i), 32'h1000 + 32'(i * 4), 8'h10);
        chk("evict stall", stall, 1);
        wait_busy("evict busy cycles", 5);
        chk("evict used", used, 1);
        chk("evict count", count, 1);
        read_chk("evict rec", 0, rec(8'h10, 32'h1000, 32'hFFFF_FFFD, 32'd4, 20'h00100));
        do_ref(20'h00100, 32'h1000, 8'h10);
        chk("evict entry invalidated", used, 1);

        // Flush: two entries with counters 9 and 5, flush with enable low
        do_reset();
        do_ref(TA, 32'h2004, 8'h21);
        period = 9'd3;
        for (int i = 0; i < 3; i++) do_ref(TQ, 32'h4000, 8'h20);
        do_ref(TB, 32'h3008, 8'h22);
        period = 9'd255;
        for (int i = 0; i < 5; i++) do_ref(TQ, 32'h4000, 8'h20);
        chk("pre-flush used", used, 0);
        en = 1'b0; flush = 1'b1;
        step();
        flush = 1'b0;
        wait_busy("flush busy cycles", NT);
        en = 1'b1;
        chk("flush used", used, 2);
        chk("flush count", count, 2);
        read_chk("flush rec0", 0, rec(8'h21, 32'h2004, 32'hFFFF_FFF7, 32'd10, TA));
        read_chk("flush rec1", 1, rec(8'h22, 32'h3008, 32'hFFFF_FFFB, 32'd10, TB));

        // Counter saturation at 2^(BW_CNT-1)-1 = 15
        do_reset();
        do_ref(TC, 32'h5000, 8'h33);
        period = 9'd255;
        for (int i = 0; i < 20; i++) do_ref(TQ, 32'h4000, 8'h20);
        do_ref(TC, 32'h5100, 8'h34);
        read_chk("sat rec", 0, rec(8'h33, 32'h5000, 32'd15, 32'd21, TC));

        // Buffer full, stalled reference, flush while full, clear, clear with write
        do_reset();
        for (int i = 0; i < 9; i++) do_ref(TA, 32'h6000, 8'h44);
        chk("full used", used, 8);
        chk("full flag", full, 1);
        chk("full stall", stall, 1);
        chk("full count", count, 8);
        read_chk("full rec0", 0, rec(8'h44, 32'h6000, 32'd1, 32'd1, TA));
        read_chk("full rec7", 7, rec(8'h44, 32'h6000, 32'd1, 32'd8, TA));
        do_ref(TA, 32'h6000, 8'h44);
        chk("stalled ref count", count, 8);
        flush = 1'b1;
        step();
        flush = 1'b0;
        wait_busy("full flush busy", NT);
        chk("full flush count", count, 9);
        chk("full flush used", used, 8);
        clear = 1'b1;
        step();
        clear = 1'b0;
        chk("clear used", used, 0);
        chk("clear full", full, 0);
        do_ref(TA, 32'h6000, 8'h44);
        do_ref(TA, 32'h6000, 8'h44);
        do_ref(TA, 32'h6000, 8'h44);
        chk("post clear used", used, 2);
        clear = 1'b1;
        do_ref(TA, 32'h6000, 8'h44);
        clear = 1'b0;
        chk("clear+write used", used, 1);
        chk("clear+write count", count, 12);
        read_chk("clear+write rec0", 0, rec(8'h44, 32'h6000, 32'd1, 32'd12, TA));
        read_chk("clear+write rd1", 1, 128'd0);

        // Asynchronous reset in the middle of an eviction
        do_reset();
        rd_addr = '0;
        do_ref(TA, 32'h7000, 8'h55);
        do_ref(TA, 32'h7000, 8'h55);
        do_ref(TB, 32'h7100, 8'h55);
        do_ref(TC, 32'h7200, 8'h55);
        do_ref(TQ, 32'h7300, 8'h55);
        chk("pre-reset busy", busy, 1);
        chk("pre-reset rd_data", rd_data, rec(8'h55, 32'h7000, 32'd1, 32'd1, TA));
        step();
        #2 rst = 1'b1;
        #1;
        chk("async rst busy", busy, 0);
        chk("async rst stall", stall, 0);
        chk("async rst used", used, 0);
        chk("async rst count", count, 0);
        chk("async rst full", full, 0);
        chk("async rst rd_data", rd_data, 0);
        step();
        rst = 1'b0;
        step();
        chk("post rst count", count, 0);
        for (int a = 0; a < NB; a++) read_chk($sformatf("post rst rd%0d", a), a, 128'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1);
    end

endmodule
